// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and sizing helpers for the ADC sample sequencer.
package adc_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, START, CONV} state_e;
  localparam int OSR_MAX_LOG2 = 7;
  function automatic int acc_width(input int adc_width);
    return adc_width + OSR_MAX_LOG2;
  endfunction
endpackage

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: free-running period counter that flags one tick per wrap while enabled.
module adc_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] period,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d, pmax;
  always_comb begin
    pmax = (period == 16'd0) ? 16'd1 : period;
    // >= rather than == so a live period decrease cannot strand the counter
    tick = en && (cnt_q >= pmax - 16'd1);
    cnt_d = (!en || tick) ? 16'd0 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/adc_sample_seq.sv
// adc_sample_seq: paces SAR conversions, averages 2^osr samples and presents results on valid/ready.
module adc_sample_seq
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [15:0]          period,
  input  logic [2:0]           osr_log2,
  output logic                 adc_start,
  input  logic                 adc_eoc,
  input  logic                 adc_den,
  input  logic [ADC_WIDTH-1:0] adc_dout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ADC_WIDTH-1:0] res_data,
  output logic                 timeout,
  output logic                 overrun,
  output logic                 tick_miss,
  input  logic                 clr_flags
);
  localparam int AW = acc_width(ADC_WIDTH);
  localparam int TW = $clog2(TIMEOUT);
  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d, sum;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           osr_q, osr_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 start_q, start_d, valid_q, valid_d, timeout_q, timeout_d;
  logic                 overrun_q, overrun_d, miss_q, miss_d;
  logic [ADC_WIDTH-1:0] data_q, data_d;
  logic                 tick, full, new_res;
  adc_tick_gen u_tick (.clk(clk), .rst_n(rst_n), .en(en), .period(period), .tick(tick));
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    osr_d     = osr_q;
    tmr_d     = tmr_q;
    timeout_d = 1'b0;
    new_res   = 1'b0;
    start_d   = en && (state_q == START);
    sum       = acc_q + AW'(adc_dout);
    full      = (cnt_q + 8'd1) == (8'd1 << osr_q);
    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = WAIT;
        WAIT:  state_d = tick ? START : WAIT;
        START: begin
          state_d = CONV;
          tmr_d   = '0;
          osr_d   = (cnt_q == 8'd0) ? osr_log2 : osr_q;
        end
        CONV: begin
          tmr_d = tmr_q + TW'(1);
          if (adc_eoc && adc_den) begin
            state_d = WAIT;
            acc_d   = full ? '0 : sum;
            cnt_d   = full ? 8'd0 : cnt_q + 8'd1;
            new_res = full;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d   = WAIT;
            timeout_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    data_d    = new_res ? ADC_WIDTH'(sum >> osr_q) : data_q;
    valid_d   = new_res | (valid_q & ~res_ready);
    overrun_d = (overrun_q & ~clr_flags) | (new_res & valid_q & ~res_ready);
    miss_d    = (miss_q & ~clr_flags) | (tick & (state_q != WAIT));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      osr_q     <= '0;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      osr_q     <= osr_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      miss_q    <= miss_d;
    end
  assign adc_start = start_q;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;
  assign tick_miss = miss_q;
endmodule

// File: tb/tb_adc_sample_seq.sv
// tb_adc_sample_seq: table vectors, corner-case sequences and random averaging against a reference model.
module tb_adc_sample_seq;
  logic        clk = 0, rst_n = 0, en = 0, res_ready = 1, clr_flags = 0;
  logic [15:0] period = 16'd20;
  logic [2:0]  osr_log2 = 3'd0;
  logic        adc_start, adc_eoc = 0, adc_den = 0;
  logic [7:0]  adc_dout = 0;
  logic        res_valid, timeout, overrun, tick_miss;
  logic [7:0]  res_data;

  adc_sample_seq #(.ADC_WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .osr_log2(osr_log2),
    .adc_start(adc_start), .adc_eoc(adc_eoc), .adc_den(adc_den), .adc_dout(adc_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .timeout(timeout), .overrun(overrun), .tick_miss(tick_miss), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // SAR model: answers each start pulse after a delay, driven on the falling edge
  logic [7:0] samp_q[$];
  int start_cyc[$];
  int pend = 0, resp_delay = 10, resp_cnt = 0, eoc_cyc = -10;
  bit resp_rand = 0, resp_den = 1;
  always @(negedge clk) begin
    adc_eoc = 0;
    adc_den = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        adc_eoc = 1;
        adc_den = resp_den;
        if (resp_den) begin
          adc_dout = (samp_q.size() != 0) ? samp_q.pop_front() : 8'($urandom);
          resp_cnt++;
          eoc_cyc = cyc;
        end else adc_dout = 8'hEE;
      end
    end
    if (adc_start) begin
      start_cyc.push_back(cyc);
      pend = resp_rand ? int'($urandom_range(9, 15)) : resp_delay;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin step(); if (res_valid) break; end
    if (k == 3000) check({name, "_wait"}, 0, 1);
  endtask
  task automatic wait_starts(input int n);
    int k;
    for (k = 0; k < 3000; k++) begin if (start_cyc.size() >= n) break; step(); end
    if (k == 3000) check("start_wait", 0, 1);
  endtask
  task automatic quiesce();
    en = 0;
    step(20);
    samp_q.delete();
    start_cyc.delete();
  endtask

  typedef struct { logic [2:0] osr; logic [7:0] s[8]; logic [7:0] exp; } vec_t;
  vec_t tbl[6];
  int expq[$];

  initial begin
    int base, k, s1, sum;
    logic [7:0] v;
    tbl[0] = '{osr: 3'd0, s: '{8'hA5, 0, 0, 0, 0, 0, 0, 0}, exp: 8'hA5};
    tbl[1] = '{osr: 3'd2, s: '{8'h10, 8'h20, 8'h30, 8'h41, 0, 0, 0, 0}, exp: 8'h28};
    tbl[2] = '{osr: 3'd1, s: '{8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0}, exp: 8'hFF};
    tbl[3] = '{osr: 3'd1, s: '{8'h01, 8'h02, 0, 0, 0, 0, 0, 0}, exp: 8'h01};
    tbl[4] = '{osr: 3'd3, s: '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, exp: 8'h03};
    tbl[5] = '{osr: 3'd3, s: '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, exp: 8'h80};

    step(3);
    check("rst_start", adc_start, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tick_miss", tick_miss, 0);
    rst_n = 1;
    step(2);

    for (int i = 0; i < 6; i++) begin
      quiesce();
      osr_log2 = tbl[i].osr;
      for (int j = 0; j < (1 << tbl[i].osr); j++) samp_q.push_back(tbl[i].s[j]);
      en = 1;
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d_data", i), res_data, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), cyc - eoc_cyc, 1);
      if (i == 0) begin
        wait_starts(3);
        check("start_space1", start_cyc[1] - start_cyc[0], 20);
        check("start_space2", start_cyc[2] - start_cyc[1], 20);
        step();
        check("start_width", adc_start, 0);
      end
    end

    // backpressure across two groups, then flag clear and drain
    quiesce();
    osr_log2 = 0; res_ready = 0;
    samp_q.push_back(8'h11); samp_q.push_back(8'h22);
    base = resp_cnt; en = 1;
    for (k = 0; k < 500; k++) begin step(); if (resp_cnt >= base + 2) break; end
    en = 0;
    check("bp_valid", res_valid, 1);
    check("bp_data", res_data, 8'h22);
    check("bp_overrun", overrun, 1);
    clr_flags = 1; step(); clr_flags = 0;
    check("bp_clr_overrun", overrun, 0);
    check("bp_hold_valid", res_valid, 1);
    res_ready = 1; step();
    check("bp_drain", res_valid, 0);

    // timeout with a den-less eoc, partial group retained
    quiesce();
    period = 16'd100; osr_log2 = 1;
    samp_q.push_back(8'h40);
    base = resp_cnt; en = 1;
    for (k = 0; k < 500; k++) begin step(); if (resp_cnt >= base + 1) break; end
    resp_den = 0;
    wait_starts(2);
    s1 = start_cyc[1];
    for (k = 0; k < 500; k++) begin if (timeout) break; step(); end
    check("to_delay", cyc - s1, 64);
    step();
    check("to_pulse_width", timeout, 0);
    resp_den = 1;
    samp_q.push_back(8'h60);
    wait_valid("to_result");
    check("to_partial_kept", res_data, 8'h50);
    check("to_next_start", start_cyc[2] - start_cyc[1], 100);

    // period shorter than a conversion
    quiesce();
    clr_flags = 1; step(); clr_flags = 0;
    check("sp_flag_clear", tick_miss, 0);
    period = 16'd4; osr_log2 = 0;
    samp_q.push_back(8'h33); samp_q.push_back(8'h44);
    en = 1;
    wait_valid("sp_r1");
    check("sp_data1", res_data, 8'h33);
    wait_valid("sp_r2");
    check("sp_data2", res_data, 8'h44);
    check("sp_tick_miss", tick_miss, 1);

    // disable mid-conversion; the late 0xFF must not be averaged in
    quiesce();
    period = 16'd20; osr_log2 = 1;
    samp_q.push_back(8'hFF);
    en = 1;
    wait_starts(1);
    step(3);
    en = 0;
    step(14);
    samp_q.push_back(8'h10); samp_q.push_back(8'h30);
    en = 1;
    wait_valid("dis_result");
    check("dis_fresh_avg", res_data, 8'h20);

    // asynchronous reset in the middle of a conversion
    base = start_cyc.size();
    wait_starts(base + 1);
    step(3);
    #3 rst_n = 0;
    #1;
    check("ar_start", adc_start, 0);
    check("ar_valid", res_valid, 0);
    check("ar_data", res_data, 0);
    check("ar_timeout", timeout, 0);
    check("ar_overrun", overrun, 0);
    check("ar_tick_miss", tick_miss, 0);
    en = 0;
    step(2);
    rst_n = 1;

    // random groups against an arithmetic average model
    quiesce();
    resp_rand = 1; res_ready = 1;
    for (int r = 0; r < 3; r++) begin
      osr_log2 = 3'($urandom_range(0, 3));
      period = 16'($urandom_range(20, 40));
      expq.delete();
      for (int g = 0; g < 4; g++) begin
        sum = 0;
        for (int j = 0; j < (1 << osr_log2); j++) begin
          v = 8'($urandom);
          samp_q.push_back(v);
          sum += v;
        end
        expq.push_back(sum >> osr_log2);
      end
      en = 1;
      for (int g = 0; g < 4; g++) begin
        wait_valid($sformatf("rnd%0d_%0d", r, g));
        check($sformatf("rnd%0d_%0d_data", r, g), res_data, expq[g]);
      end
      quiesce();
    end
    check("rnd_overrun", overrun, 0);
    check("rnd_tick_miss", tick_miss, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
